kb_fifo: RTL
============

Name: kb_fifo

Overview:
- Scancode buffer between the PS/2 receiver (done/data strobe) and the CPU port router (keyboard data port 0x22, status port).
- Absorbs bursts of bytes so the CPU does not lose scancodes while an earlier keyboard interrupt is still being serviced.
- Presents a show-ahead head byte, status flags and a level interrupt request to the IRQ queue logic.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clock  in  1  system clock (25 MHz domain, same as ps2 and the core).
- reset  in  1  synchronous, active-high reset.
- kb_done  in  1  one-cycle strobe from ps2: kb_data is valid.
- kb_data  in  8  received scancode byte.
- rd  in  1  pop strobe; one cycle per CPU read of port 0x22.
- clr  in  1  flush strobe; empties the FIFO and clears overflow.
- irq_en  in  1  interrupt enable (intmask bit 1).
- dout  out  8  head byte; 8'h00 when empty.
- count  out  AW+1  number of bytes held, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: at least one byte was dropped.
- irq  out  1  level request: irq_en & ~empty.

Behaviour:
- Reset: both pointers 0, count 0, overflow 0. Outputs: dout 8'h00, empty 1, full 0, irq 0. Memory contents are don't-care.
- Storage: DEPTH x 8 register array, write pointer wptr[AW-1:0] and read pointer rptr[AW-1:0]. Both pointers wrap modulo DEPTH with no special case.
- Push: kb_done & ~full → mem[wptr] <= kb_data, wptr+1, count+1.
- Drop: kb_done & full & ~rd → byte dropped, overflow <= 1.
- Pop: rd & ~empty → rptr+1, count-1.
- Pop when empty: ignored. No pointer movement, no error flag.
- Push and pop in the same cycle: both take effect and count is unchanged. This applies when full (the push is accepted, not dropped) and when empty (see next rule).
- Push and pop in the same cycle with the FIFO empty: the pop is ignored and the push is accepted. count becomes 1.
- dout = mem[rptr], combinational from registered state.
  - Latency: a byte pushed at edge N appears on dout after edge N, when the FIFO was empty before it.
  - After a pop at edge N, dout shows the next byte after edge N.
- clr has priority over push and pop in the same cycle: pointers 0, count 0, overflow 0, and the incoming byte is discarded.
- overflow holds until clr or reset. Pops do not clear it.
- irq is a level signal. The IRQ logic upstream of the core converts it to a toggle; kb_fifo generates no edges itself.
- reset mid-burst: every byte is lost and the next kb_done after reset is stored at index 0.

Optional Feature:
- Macro: KB_FIFO_BREAK_FILTER_EN.
- Defined: adds a 1-bit state machine in front of the push path.
  - IDLE: byte 8'hF0 → go to BRK without pushing. Any other byte (including 8'hE0) is pushed normally.
  - BRK: the next byte is discarded → IDLE.
  - Effect: key releases are never buffered. clr and reset return the state machine to IDLE.
  - A byte discarded in BRK never sets overflow.
- Not defined: every byte is pushed unmodified and no state register exists.

Decomposition:
- Package kb_fifo_pkg holds:
  - constants KB_BREAK = 8'hF0 and KB_EXT = 8'hE0;
  - status bit positions STAT_EMPTY = 0, STAT_FULL = 1, STAT_OVF = 2. The port router packs {overflow, full, empty} into the status port from these.
- One sub-module: kb_break_filter, a 2-state filter between kb_done/kb_data and the push logic. It is instantiated only under KB_FIFO_BREAK_FILTER_EN.

Test Plan:
- Reset, then push 8'h1C, 8'h32, 8'h21 → count=3, dout=8'h1C, irq=1 with irq_en=1. Three rd pulses → dout 8'h32, 8'h21, then 8'h00 with empty=1.
- Push 17 bytes 8'h01..8'h11 with DEPTH=16 → full=1, count=16, overflow=1. Popping all yields 8'h01..8'h10 and never 8'h11.
- Full FIFO, kb_done and rd in the same cycle with 8'hAA → count stays 16, overflow stays 0, and 8'hAA is the last byte popped.
- Empty FIFO, kb_done=8'h5A with rd in the same cycle → count=1, dout=8'h5A. Then rd with empty → no change.
- 40 push/pop pairs, so both pointers wrap twice → data order preserved. clr asserted with kb_done → count=0, overflow=0, byte discarded.
- With KB_FIFO_BREAK_FILTER_EN, sequence 8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75 → FIFO holds 8'h1C, 8'hE0, 8'h75 and count=3.

Source files
------------

// File: rtl/kb_fifo_pkg.sv
// kb_fifo_pkg: scancode constants, status bit positions and break-filter state type
package kb_fifo_pkg;

    localparam logic [7:0] KB_BREAK = 8'hF0;
    localparam logic [7:0] KB_EXT   = 8'hE0;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic {FLT_IDLE, FLT_BRK} flt_state_t;

endpackage

// File: rtl/kb_break_filter.sv
// kb_break_filter: drops 8'hF0 break prefixes and the byte that follows them
module kb_break_filter
    import kb_fifo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       kb_done,
    input  logic [7:0] kb_data,
    output logic       wr_req
);

    flt_state_t state, state_next;

    // state register; a flush also forgets a pending break prefix
    always_ff @(posedge clock) begin
        state <= (reset || clr) ? FLT_IDLE : state_next;
    end

    // next state and push request: only non-prefix bytes seen in IDLE are forwarded
    always_comb begin
        state_next = state;
        wr_req     = 1'b0;
        if (kb_done) begin
            if (state == FLT_BRK)
                state_next = FLT_IDLE;
            else if (kb_data == KB_BREAK)
                state_next = FLT_BRK;
            else
                wr_req = 1'b1;
        end
    end

endmodule

// File: rtl/kb_fifo.sv
// kb_fifo: show-ahead scancode FIFO with sticky overflow and level irq.
// Define KB_FIFO_BREAK_FILTER_EN to discard key-release sequences before buffering.
module kb_fifo
    import kb_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          kb_done,
    input  logic [7:0]    kb_data,
    input  logic          rd,
    input  logic          clr,
    input  logic          irq_en,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          irq
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          wr_req, push, pop, drop;

`ifdef KB_FIFO_BREAK_FILTER_EN
    kb_break_filter u_filter (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .kb_done (kb_done),
        .kb_data (kb_data),
        .wr_req  (wr_req)
    );
`else
    assign wr_req = kb_done;
`endif

    assign empty    = count == '0;
    assign full     = count == (AW+1)'(DEPTH);
    assign push     = wr_req & (~full | rd);
    assign pop      = rd & ~empty;
    assign drop     = wr_req & full & ~rd;
    assign dout     = empty ? 8'h00 : mem[rptr];
    assign irq      = irq_en & ~empty;

    // pointers, occupancy and sticky overflow; clr outranks push and pop
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (drop) overflow <= 1'b1;
        end
    end

    // byte storage, no reset needed since dout is masked while empty
    always_ff @(posedge clock) begin
        if (push && !reset && !clr) mem[wptr] <= kb_data;
    end

endmodule
